gray_conv_arbiter: RTL and testbench
====================================

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 4, width of Gray input and binary output.
- CNT_W, default 8, width of the completed-transfer counter.

REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0  input  1  requester 0 conversion request.
- gray0  input  WIDTH  requester 0 Gray code operand.
- req1  input  1  requester 1 conversion request.
- gray1  input  WIDTH  requester 1 Gray code operand.
- gnt0  output  1  one-cycle pulse; requester 0 operand captured.
- gnt1  output  1  one-cycle pulse; requester 1 operand captured.
- out_valid  output  1  bin_out/out_src hold a result.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  WIDTH  binary result.
- out_src  output  1  requester that produced bin_out (0 or 1).
- busy  output  1  high in any state other than IDLE.
- conv_cnt  output  CNT_W  count of accepted results.

Function
REQ-003 The block SHALL share one Gray-to-binary converter between two requesters. Conversion rule: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i] for i < WIDTH-1.
REQ-004 The FSM SHALL have exactly three states: IDLE, CONV, HOLD.
REQ-005 IDLE with no request at a clock edge: the FSM SHALL stay in IDLE.
REQ-006 IDLE with at least one req at a clock edge: the block SHALL, on that edge, do all of the following:
- select a winner;
- capture the winner's gray into an operand register;
- record the winner in out_src;
- assert the winner's gnt for exactly the following cycle;
- move to CONV.
REQ-007 Arbitration SHALL be round-robin. The requester not served last wins a tie. After reset, requester 0 has priority.
REQ-008 CONV SHALL last one cycle. On its exiting edge the block SHALL load bin_out with the converted operand, set out_valid = 1, and move to HOLD.
REQ-009 In HOLD, bin_out, out_src and out_valid SHALL remain stable until an edge with out_ready = 1.
REQ-010 On that HOLD edge with out_ready = 1, the block SHALL:
- clear out_valid;
- increment conv_cnt, wrapping from 2^CNT_W-1 to 0;
- update the last-served record to out_src;
- return to IDLE.
REQ-011 out_ready SHALL be ignored outside HOLD.
REQ-012 Latency SHALL be fixed: req sampled at edge k, then gnt high during cycle k..k+1 and out_valid high from edge k+1. Minimum spacing between grants is 3 cycles when out_ready is held high.
REQ-013 gnt0 and gnt1 SHALL never be high in the same cycle. No gnt SHALL be asserted outside the cycle after an IDLE capture.
REQ-014 A requester SHALL hold req and gray stable until it sees its gnt. A req deasserted before being sampled in IDLE SHALL have no effect.
REQ-015 Requests arriving during CONV or HOLD SHALL be held off, not lost, provided the requester keeps req high. Such a request is arbitrated on the first IDLE edge.
REQ-016 The operand register SHALL isolate the result: changes on gray0/gray1 after capture SHALL NOT affect bin_out.

Reset
REQ-017 While rst is high, asynchronously, the block SHALL force:
- state = IDLE;
- gnt0 = gnt1 = out_valid = busy = 0;
- bin_out = 0, out_src = 0, conv_cnt = 0;
- last-served = 1, so requester 0 has priority.
REQ-018 Reset asserted mid-operation (CONV or HOLD) SHALL discard the pending result and SHALL NOT increment conv_cnt.
REQ-019 The first capture after reset SHALL be at the first rising edge at which rst is low and a req is high.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single request: req0 = 1, gray0 = 0110, out_ready = 1 -> gnt0 pulse, out_valid at edge k+1, bin_out = 0100, out_src = 0, conv_cnt = 1.
- Simultaneous requests after reset: req0 = req1 = 1, gray0 = 1000, gray1 = 1111 -> first result bin_out = 1000→1111 with out_src = 0, then bin_out = 1010 with out_src = 1; gnt pulses never overlap.
- Backpressure: out_ready = 0 for 5 cycles after out_valid, gray0 = 0011 -> bin_out = 0010 held stable with out_valid = 1; req1 pending gets no gnt until out_ready = 1.
- Exhaustive sweep: all 16 Gray codes 0000..1111 through each requester -> bin_out matches REQ-003 for every code; conv_cnt = 32.
- Reset in HOLD: rst pulsed while out_valid = 1 -> all outputs zero immediately, conv_cnt = 0, next tie goes to requester 0.
- Counter wrap: CNT_W = 2, 5 accepted results -> conv_cnt reads 1,2,3,0,1.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
//
// Purpose: two requesters share one Gray-to-binary converter. A round-robin
// arbiter picks a winner in IDLE and captures its Gray operand. After one
// conversion cycle (CONV) the result is held (HOLD) until the consumer takes it.
//
// Handshakes:
//   req/gnt       - a requester raises req with a stable gray operand and keeps
//                   both steady until it sees its gnt pulse. gnt is high for
//                   exactly the one cycle after the capture edge. A req dropped
//                   before an IDLE edge samples it is simply never seen.
//   out_valid/out_ready - while out_valid is high, bin_out/out_src do not change.
//                   The result transfers on a rising edge where both are high.
//                   out_ready has no effect while out_valid is low.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req0/gray0        requester 0 request and Gray operand
//   req1/gray1        requester 1 request and Gray operand
//   gnt0/gnt1         one-cycle capture pulses (never both high)
//   out_valid         bin_out/out_src hold a result
//   out_ready         consumer accepts the result
//   bin_out           binary result
//   out_src           requester that produced bin_out
//   busy              FSM is not in IDLE
//   conv_cnt          count of accepted results (wraps)
// -----------------------------------------------------------------------------
module gray_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] gray0,
    input  logic             req1,
    input  logic [WIDTH-1:0] gray1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_src,
    output logic             busy,
    output logic [CNT_W-1:0] conv_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             src_q, src_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             winner;
    logic [WIDTH-1:0] conv_bin;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above
    // it, accumulated from the MSB down.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        conv_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc         = acc ^ opnd_q[i];
            conv_bin[i] = acc;
        end
    end

    // Round-robin: on a tie the requester that was not served last wins.
    // last_q resets to 1 so requester 0 has priority out of reset.
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_q;
        end else begin
            winner = req1;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        bin_d   = bin_q;
        src_d   = src_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    src_d   = winner;
                    opnd_d  = winner ? gray1 : gray0;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    state_d = CONV;
                end
            end
            CONV: begin
                bin_d   = conv_bin;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    last_d  = src_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            bin_q   <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            bin_q   <= bin_d;
            src_q   <= src_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign out_valid = valid_q;
    assign bin_out   = bin_q;
    assign out_src   = src_q;
    assign busy      = (state_q != IDLE);
    assign conv_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_arbiter
//
// Directed bench for gray_conv_arbiter. Two instances share all inputs: the
// default one (CNT_W = 8) and a narrow-counter one (CNT_W = 2) used to observe
// counter wrap. Expected binary values come from a hand-written Gray table.
// -----------------------------------------------------------------------------
module tb_gray_conv_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] gray0 = 4'd0;
    logic [3:0] gray1 = 4'd0;
    logic       out_ready = 1'b0;

    logic       gnt0, gnt1, out_valid, out_src, busy;
    logic [3:0] bin_out;
    logic [7:0] conv_cnt;

    logic       gnt0_w, gnt1_w, out_valid_w, out_src_w, busy_w;
    logic [3:0] bin_out_w;
    logic [1:0] conv_cnt_w;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    logic [3:0] bin_tab [16];
    logic [1:0] wrap_tab [5];

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUTs
    gray_conv_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .gray0     (gray0),
        .req1      (req1),
        .gray1     (gray1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .out_src   (out_src),
        .busy      (busy),
        .conv_cnt  (conv_cnt)
    );

    gray_conv_arbiter #(.WIDTH(4), .CNT_W(2)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .gray0     (gray0),
        .req1      (req1),
        .gray1     (gray1),
        .gnt0      (gnt0_w),
        .gnt1      (gnt1_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .bin_out   (bin_out_w),
        .out_src   (out_src_w),
        .busy      (busy_w),
        .conv_cnt  (conv_cnt_w)
    );

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    // One complete transfer from a single requester with out_ready high.
    // Called with the FSM in IDLE; returns #1 after the accepting edge.
    task automatic xfer_single(input logic who, input logic [3:0] g, input logic [3:0] exp_bin);
        @(negedge clk);
        out_ready = 1'b1;
        if (!who) begin
            req0 = 1'b1; gray0 = g;
        end else begin
            req1 = 1'b1; gray1 = g;
        end
        tick();
        check("xfer_gnt", {gnt1, gnt0}, who ? 2'b10 : 2'b01);
        check("xfer_gnt_w", {gnt1_w, gnt0_w}, who ? 2'b10 : 2'b01);
        check("xfer_busy", busy, 1);
        check("xfer_valid_early", out_valid, 0);
        // Requester saw its gnt: release and scramble the operand.
        if (!who) begin
            req0 = 1'b0; gray0 = ~g;
        end else begin
            req1 = 1'b0; gray1 = ~g;
        end
        tick();
        check("xfer_valid", out_valid, 1);
        check("xfer_bin", bin_out, exp_bin);
        check("xfer_src", out_src, who);
        check("xfer_gnt_off", {gnt1, gnt0}, 2'b00);
        check("xfer_w_out", {out_valid_w, out_src_w, bin_out_w}, {1'b1, who, exp_bin});
        tick();
        exp_cnt++;
        check("xfer_accept_valid", out_valid, 0);
        check("xfer_idle", {busy, busy_w}, 2'b00);
        check("xfer_cnt", conv_cnt, exp_cnt[7:0]);
        check("xfer_cnt_w", conv_cnt_w, exp_cnt[1:0]);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        bin_tab[0]  = 4'b0000; bin_tab[1]  = 4'b0001; bin_tab[2]  = 4'b0011; bin_tab[3]  = 4'b0010;
        bin_tab[4]  = 4'b0111; bin_tab[5]  = 4'b0110; bin_tab[6]  = 4'b0100; bin_tab[7]  = 4'b0101;
        bin_tab[8]  = 4'b1111; bin_tab[9]  = 4'b1110; bin_tab[10] = 4'b1100; bin_tab[11] = 4'b1101;
        bin_tab[12] = 4'b1000; bin_tab[13] = 4'b1001; bin_tab[14] = 4'b1011; bin_tab[15] = 4'b1010;
        wrap_tab[0] = 2'd1; wrap_tab[1] = 2'd2; wrap_tab[2] = 2'd3; wrap_tab[3] = 2'd0; wrap_tab[4] = 2'd1;

        // Reset state, observed while rst is still high.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_gnt", {gnt1, gnt0}, 2'b00);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bin", bin_out, 0);
        check("rst_src", out_src, 0);
        check("rst_cnt", conv_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        // Idle with no request stays idle.
        tick();
        check("idle_stay", {busy, gnt1, gnt0}, 3'b000);

        // Single request: 0110 -> 0100.
        xfer_single(1'b0, 4'b0110, 4'b0100);

        // Simultaneous requests after reset: requester 0 first, then 1.
        apply_reset();
        @(negedge clk);
        out_ready = 1'b1;
        req0 = 1'b1; gray0 = 4'b1000;
        req1 = 1'b1; gray1 = 4'b1111;
        tick();
        check("tie_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        tick();
        check("tie_bin0", {out_valid, out_src, bin_out}, {1'b1, 1'b0, 4'b1111});
        check("tie_gnt_off0", {gnt1, gnt0}, 2'b00);
        tick();
        check("tie_cnt1", conv_cnt, 1);
        check("tie_held_gnt", {gnt1, gnt0}, 2'b00);
        tick();
        check("tie_gnt1", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        tick();
        check("tie_bin1", {out_valid, out_src, bin_out}, {1'b1, 1'b1, 4'b1010});
        check("tie_gnt_off1", {gnt1, gnt0}, 2'b00);
        tick();
        check("tie_cnt2", conv_cnt, 2);
        exp_cnt = 2;

        // Backpressure: hold 0011 -> 0010 for 5 cycles, req1 waits.
        @(negedge clk);
        out_ready = 1'b0;
        req0 = 1'b1; gray0 = 4'b0011;
        tick();
        check("bp_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0; gray0 = 4'b1100;
        req1 = 1'b1; gray1 = 4'b0101;
        tick();
        check("bp_first", {out_valid, out_src, bin_out}, {1'b1, 1'b0, 4'b0010});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {out_valid, out_src, bin_out}, {1'b1, 1'b0, 4'b0010});
            check("bp_no_gnt", {busy, gnt1, gnt0}, 3'b100);
            check("bp_cnt", conv_cnt, 2);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", {out_valid, gnt1, gnt0}, 3'b000);
        check("bp_cnt3", conv_cnt, 3);
        tick();
        check("bp_gnt1", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        tick();
        check("bp_bin1", {out_valid, out_src, bin_out}, {1'b1, 1'b1, 4'b0110});
        tick();
        check("bp_cnt4", conv_cnt, 4);
        exp_cnt = 4;

        // Exhaustive sweep through both requesters.
        apply_reset();
        for (int i = 0; i < 16; i++) xfer_single(1'b0, 4'(i), bin_tab[i]);
        for (int i = 0; i < 16; i++) xfer_single(1'b1, 4'(i), bin_tab[i]);
        check("sweep_cnt", conv_cnt, 32);

        // Reset while holding a result.
        @(negedge clk);
        out_ready = 1'b0;
        req0 = 1'b1; gray0 = 4'b0110;
        tick();
        req0 = 1'b0;
        tick();
        check("rh_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rh_outs", {gnt1, gnt0, out_valid, busy, out_src, bin_out}, 9'd0);
        check("rh_cnt", conv_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        out_ready = 1'b1;
        req0 = 1'b1; gray0 = 4'b0001;
        req1 = 1'b1; gray1 = 4'b0010;
        tick();
        check("rh_tie_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        tick();
        check("rh_bin0", {out_valid, out_src, bin_out}, {1'b1, 1'b0, 4'b0001});
        tick();
        check("rh_cnt1", conv_cnt, 1);
        tick();
        check("rh_gnt1", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        tick();
        check("rh_bin1", {out_valid, out_src, bin_out}, {1'b1, 1'b1, 4'b0011});
        tick();
        check("rh_cnt2", conv_cnt, 2);

        // Counter wrap on the 2-bit instance.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            xfer_single(i[0], 4'(i + 3), bin_tab[i + 3]);
            check("wrap_cnt", conv_cnt_w, wrap_tab[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
